// File: rtl/vedic_pkg.sv
// Shared helpers for the pipelined Vedic multiplier: width legality,
// pipeline depth derivation and two's-complement sign handling.
package vedic_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int unsigned latency_of(input int unsigned w);
    return clog2(w);
  endfunction

  function automatic bit width_ok(input int unsigned w);
    return (w == 4) || (w == 8) || (w == 16);
  endfunction

  function automatic logic [31:0] negate(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Callers truncate the result, so the 32-bit negate yields the correct
  // narrow magnitude (including 2^(W-1) for the most negative operand).
  function automatic logic [31:0] mag_of(input logic [31:0] x, input logic neg);
    return neg ? negate(x) : x;
  endfunction

endpackage

// File: rtl/vedic_2x2.sv
// Combinational 2x2 Urdhva-Tiryagbhyam leaf: vertical, crosswise, vertical.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic hi;
  logic c1;

  always_comb begin
    hi   = a[1] & b[1];
    c1   = (a[1] & b[0]) & (a[0] & b[1]);
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    p[2] = hi ^ c1;
    p[3] = hi & c1;
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined WIDTHxWIDTH Vedic multiplier with signed/unsigned mode and
// valid/ready handshaking; one stage per doubling of sub-product width.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned LATENCY = latency_of(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be 4, 8 or 16");
  end

  logic             advance;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             sign_d;

  always_comb begin
    sign_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    a_mag  = WIDTH'(mag_of(32'(a), is_signed && a[WIDTH-1]));
    b_mag  = WIDTH'(mag_of(32'(b), is_signed && b[WIDTH-1]));
  end

  assign advance  = ena && (!out_valid || out_ready);
  assign in_ready = advance;

  // Level k holds products of S-bit operand blocks, S = 2^(k+1); the last
  // level's single entry is the signed result and only loads on valid data.
  for (genvar k = 0; k < LATENCY; k++) begin : g_lvl
    localparam int unsigned S  = 2 << k;
    localparam int unsigned NB = WIDTH / S;
    localparam int unsigned PW = 2 * S;

    logic          v;
    logic          sgn;
    logic [PW-1:0] prod_q [NB][NB];

    if (k == 0) begin : g_leaf
      logic [3:0] pp [NB][NB];

      for (genvar i = 0; i < NB; i++) begin : g_row
        for (genvar j = 0; j < NB; j++) begin : g_col
          vedic_2x2 u_pp (
            .a (a_mag[2*i +: 2]),
            .b (b_mag[2*j +: 2]),
            .p (pp[i][j])
          );
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v      <= 1'b0;
          sgn    <= 1'b0;
          prod_q <= '{default: '0};
        end else if (advance) begin
          v      <= in_valid;
          sgn    <= sign_d;
          prod_q <= pp;
        end
      end
    end else begin : g_comb
      localparam int unsigned H = S / 2;

      logic [PW-1:0] sum_d [NB][NB];

      // Block (i,j) = lo*lo + (hi*lo + lo*hi) << H + hi*hi << S.
      always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
          for (int unsigned j = 0; j < NB; j++) begin
            sum_d[i][j] = PW'(g_lvl[k-1].prod_q[2*i][2*j])
                        + ((PW'(g_lvl[k-1].prod_q[2*i+1][2*j])
                          + PW'(g_lvl[k-1].prod_q[2*i][2*j+1])) << H)
                        + (PW'(g_lvl[k-1].prod_q[2*i+1][2*j+1]) << S);
          end
        end
      end

      if (k == LATENCY - 1) begin : g_out
        assign sgn = g_lvl[k-1].sgn;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v      <= 1'b0;
            prod_q <= '{default: '0};
          end else if (advance) begin
            v <= g_lvl[k-1].v;
            if (g_lvl[k-1].v) prod_q[0][0] <= PW'(mag_of(32'(sum_d[0][0]), sgn));
          end
        end
      end else begin : g_mid
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v      <= 1'b0;
            sgn    <= 1'b0;
            prod_q <= '{default: '0};
          end else if (advance) begin
            v      <= g_lvl[k-1].v;
            sgn    <= g_lvl[k-1].sgn;
            prod_q <= sum_d;
          end
        end
      end
    end
  end

  assign out_valid = g_lvl[LATENCY-1].v;
  assign p         = g_lvl[LATENCY-1].prod_q[0][0];

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench: three multiplier widths (4/8/16) checked against an
// arithmetic reference multiply; monitors pop expectations on each transfer.
module tb_vedic_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  iv;
  logic [2:0]  sg;
  logic [2:0]  ordy;
  logic [2:0]  ov_s;
  logic [2:0]  ir_s;
  logic [15:0] a_d [3];
  logic [15:0] b_d [3];
  logic [63:0] expq [3][$];

  int vectors;
  int miscompares;
  int done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: interpret operands at width w, multiply as integers, wrap to 2w bits.
  function automatic logic [63:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input int unsigned w);
    longint xv, yv, pr, full;
    full = longint'(1) << w;
    xv = longint'(x) % full;
    yv = longint'(y) % full;
    if (s && xv >= full / 2) xv = xv - full;
    if (s && yv >= full / 2) yv = yv - full;
    pr = xv * yv;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = 4 << g;
    logic [2*W-1:0] p_w;
    logic           ov;
    logic           ir;

    vedic_mult_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (en[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir),
      .a         (a_d[g][W-1:0]),
      .b         (b_d[g][W-1:0]),
      .is_signed (sg[g]),
      .out_valid (ov),
      .out_ready (ordy[g]),
      .p         (p_w)
    );

    assign ov_s[g] = ov;
    assign ir_s[g] = ir;

    always @(negedge clk) begin
      if (rst_n) begin
        if (en[g] && ov && ordy[g]) begin
          if (expq[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL w%0d_unexpected_out: got p=0x%0h with no result outstanding, required none", W, p_w);
          end else begin
            chk($sformatf("w%0d_product", W), 64'(p_w), expq[g].pop_front());
          end
        end
        if (iv[g] && ir) expq[g].push_back(model(a_d[g], b_d[g], sg[g], W));
      end
    end
  end

  task automatic send(input int g, input logic [15:0] av, input logic [15:0] bv, input logic s);
    int unsigned t;
    t = 0;
    a_d[g] = av;
    b_d[g] = bv;
    sg[g]  = s;
    iv[g]  = 1'b1;
    @(negedge clk);
    while (!ir_s[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir_s[g]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout dut%0d: in_ready=0, required 1", g);
    end
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int unsigned t;
    t = 0;
    while (expq[g].size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_dut%0d", g), 64'(expq[g].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_probe(input int g, input int unsigned lat);
    int unsigned e;
    e = 0;
    send(g, 16'($urandom()), 16'($urandom()), 1'b0);
    while (!ov_s[g] && e < 50) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk($sformatf("latency_dut%0d", g), 64'(e), 64'(lat - 1));
    drain(g);
  endtask

  initial begin
    logic [7:0] p_snap;
    logic       ov_snap;
    int unsigned t;

    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    en = 3'b111;
    iv = 3'b000;
    sg = 3'b000;
    ordy = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_d[i] = '0;
      b_d[i] = '0;
    end

    // Reset state
    #12;
    chk("reset_ov", 64'(ov_s), 64'd0);
    chk("reset_p4", 64'(g_dut[0].p_w), 64'd0);
    chk("reset_p8", 64'(g_dut[1].p_w), 64'd0);
    chk("reset_p16", 64'(g_dut[2].p_w), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(ir_s), 64'd7);
    en[0] = 1'b0;
    #1;
    chk("in_ready_ena_low", 64'(ir_s[0]), 64'd0);
    en[0] = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned stream, back to back
    send(0, 16'd5, 16'd3, 1'b0);
    send(0, 16'd2, 16'd7, 1'b0);
    send(0, 16'd4, 16'd9, 1'b0);
    send(0, 16'd15, 16'd15, 1'b0);
    send(0, 16'd9, 16'd0, 1'b0);
    drain(0);

    // Signed corner cases (4-bit patterns)
    send(0, 16'h8, 16'h8, 1'b1);
    send(0, 16'hF, 16'h7, 1'b1);
    send(0, 16'h8, 16'h7, 1'b1);
    send(0, 16'h7, 16'h7, 1'b1);
    drain(0);

    lat_probe(0, 2);
    lat_probe(1, 3);
    lat_probe(2, 4);

    // Backpressure: hold out_ready low 3 cycles after first out_valid
    fork
      begin
        send(0, 16'd3, 16'd5, 1'b0);
        send(0, 16'd6, 16'd7, 1'b0);
        send(0, 16'hE, 16'h3, 1'b1);
        send(0, 16'd12, 16'd11, 1'b0);
      end
      begin
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!ov_s[0] && t < 50);
        ordy[0] = 1'b0;
        p_snap = g_dut[0].p_w;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(ir_s[0]), 64'd0);
          chk("stall_out_valid", 64'(ov_s[0]), 64'd1);
          chk("stall_p", 64'(g_dut[0].p_w), 64'(p_snap));
          @(posedge clk);
          #1;
        end
        ordy[0] = 1'b1;
      end
    join
    drain(0);

    // Enable dropped for two cycles mid-stream
    fork
      begin
        send(0, 16'd1, 16'd13, 1'b0);
        send(0, 16'd10, 16'd10, 1'b0);
        send(0, 16'h9, 16'h6, 1'b1);
        send(0, 16'd8, 16'd8, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        en[0] = 1'b0;
        p_snap = g_dut[0].p_w;
        ov_snap = ov_s[0];
        repeat (2) begin
          @(negedge clk);
          chk("ena_in_ready", 64'(ir_s[0]), 64'd0);
          chk("ena_out_valid", 64'(ov_s[0]), 64'(ov_snap));
          chk("ena_p", 64'(g_dut[0].p_w), 64'(p_snap));
          @(posedge clk);
          #1;
        end
        en[0] = 1'b1;
      end
    join
    drain(0);

    // Reset with two operations in flight
    send(0, 16'd2, 16'd3, 1'b0);
    send(0, 16'd4, 16'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_ov", 64'(ov_s[0]), 64'd0);
    chk("midreset_p", 64'(g_dut[0].p_w), 64'd0);
    for (int i = 0; i < 3; i++) expq[i].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 16'd3, 16'd3, 1'b0);
    drain(0);
    repeat (3) @(negedge clk);
    chk("post_reset_no_stale", 64'(ov_s[0]), 64'd0);

    // Random mixed-mode operands on the 8- and 16-bit instances
    fork
      begin
        send(1, 16'h00FF, 16'h00FF, 1'b0);
        for (int n = 0; n < 1000; n++)
          send(1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
        done_cnt++;
      end
      begin
        send(2, 16'h8000, 16'h8000, 1'b1);
        for (int n = 0; n < 1000; n++)
          send(2, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
        done_cnt++;
      end
      begin
        while (done_cnt < 2) begin
          @(posedge clk);
          #1;
          ordy[1] = ($urandom_range(0, 3) != 0);
          ordy[2] = ($urandom_range(0, 3) != 0);
        end
        ordy[1] = 1'b1;
        ordy[2] = 1'b1;
      end
    join
    drain(1);
    drain(2);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
